bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Sequencer that moves one word per request across the shared tri-state data bus between register8 instances.
- Drives the per-register out_en and load strobes.
- Can itself drive an external word onto the bus.
- Sits directly upstream of the register8 bank: every register's out_en/load pin is fed from this block, and its dout/din pins share the bus.

Parameters:
- data_size, 32, bus and register width
- NUM_REGS, 8, number of register8 instances on the bus (2..16)
- IDX_W, 4, width of source/destination index fields

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  transfer request present
- req_ready  output  1  controller can accept a request
- req_src  input  IDX_W  source register index (ignored when req_ext=1)
- req_dst  input  IDX_W  destination register index
- req_ext  input  1  source is ext_din instead of a register
- ext_din  input  data_size  external word, sampled at acceptance
- bus  inout  data_size  shared data bus
- reg_out_en  output  NUM_REGS  one-hot output enable to register8 instances
- reg_load  output  NUM_REGS  one-hot load strobe to register8 instances
- bus_capture  output  data_size  last word moved across the bus
- done  output  1  one-cycle pulse, transfer completed
- err  output  1  one-cycle pulse, request rejected
- xfer_count  output  16  completed-transfer counter, saturating

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, req_ready=1.
  - reg_out_en=0, reg_load=0, bus_capture=0, done=0, err=0, xfer_count=0.
  - bus released to z immediately, without waiting for a clock edge.
- All outputs registered except bus, which is driven from the registered ext-drive enable.
- FSM states: IDLE, DRIVE, LATCH, FIN, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch src/dst/ext and ext_din.
  - Next state is ERR if the request is illegal, else DRIVE.
  - Illegal request: req_dst>=NUM_REGS, or (!req_ext and req_src>=NUM_REGS), or (!req_ext and req_src==req_dst).
- DRIVE (1 cycle), bus settle:
  - Register source: reg_out_en[src]=1.
  - External source: controller drives bus=latched ext_din, and reg_out_en stays 0.
  - reg_load=0.
- LATCH (1 cycle):
  - Source enable held as in DRIVE; reg_load[dst]=1.
  - At the closing edge, the destination register captures the bus and bus_capture<=bus.
- FIN (1 cycle):
  - All enables 0, bus released.
  - done=1; xfer_count+=1, saturating at 16'hFFFF.
  - Next state IDLE.
- ERR (1 cycle):
  - err=1; no enable or load asserted; bus_capture and xfer_count unchanged.
  - Next state IDLE.
- req_ready=0 in every state except IDLE. Requests are never queued; the requester holds req_valid until accepted.
- Latency: acceptance edge to done=1 is 3 cycles; minimum request spacing is 4 cycles.
- Invariants:
  - At most one bit of reg_out_en is set at any time.
  - reg_out_en is never set while the controller drives bus.
  - At most one bit of reg_load is set at any time.
  - reg_load is only ever set in LATCH.
- Reset mid-transfer: enables drop asynchronously and the destination is not loaded. A transfer interrupted in LATCH before its clock edge does not count.

Test Plan:
- Reset check: hold reset=0 with req_valid=1 -> req_ready=1, all enables 0, bus=z, xfer_count=0. Release reset -> request accepted on the next edge.
- Reg-to-reg transfer: reg2 preloaded with 32'h1234_5678, request src=2 dst=5.
  - Cycle+1: reg_out_en=8'h04.
  - Cycle+2: reg_out_en=8'h04, reg_load=8'h20.
  - Cycle+3: done=1, reg5=32'h1234_5678, bus_capture=32'h1234_5678, xfer_count=1.
- External transfer: req_ext=1, ext_din=32'hDEAD_BEEF, dst=0.
  - Bus=32'hDEADBEEF in DRIVE and LATCH, with reg_out_en=0.
  - Then reg0=32'hDEADBEEF, done=1, bus=z in FIN.
- Illegal requests, each rejected:
  - src=3 dst=3 -> err=1 one cycle later; no strobes; xfer_count unchanged.
  - With NUM_REGS=6, dst=7 -> same response.
- Back-to-back: req_valid held high for two requests -> req_ready=0 for 3 cycles; second request accepted exactly 4 cycles after the first.
- Reset mid-transfer: assert reset during LATCH -> reg_load=0 immediately, destination keeps its old value, done never pulses, xfer_count=0.

Source files
------------

// File: rtl/bus_xfer_ctrl_if.sv
// Request/strobe bundle between a transfer requester, bus_xfer_ctrl and the register8 bank.
// The tri-state data bus itself stays a plain inout on the controller.
interface bus_xfer_ctrl_if #(
  parameter int data_size = 32,
  parameter int NUM_REGS  = 8,
  parameter int IDX_W     = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [IDX_W-1:0]     req_src;
  logic [IDX_W-1:0]     req_dst;
  logic                 req_ext;
  logic [data_size-1:0] ext_din;
  logic [NUM_REGS-1:0]  reg_out_en;
  logic [NUM_REGS-1:0]  reg_load;
  logic [data_size-1:0] bus_capture;
  logic                 done;
  logic                 err;
  logic [15:0]          xfer_count;

  modport master (
    input  req_valid, req_src, req_dst, req_ext, ext_din,
    output req_ready, reg_out_en, reg_load, bus_capture, done, err, xfer_count
  );

  modport slave (
    output req_valid, req_src, req_dst, req_ext, ext_din,
    input  req_ready, reg_out_en, reg_load, bus_capture, done, err, xfer_count
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// One-word-per-request sequencer for a shared tri-state bus between register8 instances:
// IDLE -> DRIVE (settle) -> LATCH (load strobe) -> FIN (done), or IDLE -> ERR on a bad request.
module bus_xfer_ctrl #(
  parameter int data_size = 32,
  parameter int NUM_REGS  = 8,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_xfer_ctrl_if.master      ifc,
  inout  wire  [data_size-1:0] bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, LATCH, FIN, ERR} state_t;

  state_t               state_q,     state_d;
  logic                 req_ready_q, req_ready_d;
  logic [NUM_REGS-1:0]  out_en_q,    out_en_d;
  logic [NUM_REGS-1:0]  load_q,      load_d;
  logic                 ext_drv_q,   ext_drv_d;
  logic [data_size-1:0] ext_word_q,  ext_word_d;
  logic [data_size-1:0] capture_q,   capture_d;
  logic [IDX_W-1:0]     dst_q,       dst_d;
  logic                 done_q,      done_d;
  logic                 err_q,       err_d;
  logic [15:0]          count_q,     count_d;
  logic                 accept;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) oh[i] = (32'(idx) == i);
    return oh;
  endfunction

  function automatic logic req_illegal(input logic [IDX_W-1:0] src,
                                       input logic [IDX_W-1:0] dst,
                                       input logic             ext);
    return (32'(dst) >= NUM_REGS) ||
           (!ext && (32'(src) >= NUM_REGS)) ||
           (!ext && (src == dst));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign accept = ifc.req_valid && req_ready_q;

  // Every output is computed one state ahead so it is registered in the state it belongs to.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    out_en_d    = out_en_q;
    load_d      = load_q;
    ext_drv_d   = ext_drv_q;
    ext_word_d  = ext_word_q;
    capture_d   = capture_q;
    dst_d       = dst_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    count_d     = count_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        out_en_d    = '0;
        load_d      = '0;
        ext_drv_d   = 1'b0;
        if (accept) begin
          req_ready_d = 1'b0;
          dst_d       = ifc.req_dst;
          ext_word_d  = ifc.ext_din;
          if (req_illegal(ifc.req_src, ifc.req_dst, ifc.req_ext)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d   = DRIVE;
            ext_drv_d = ifc.req_ext;
            out_en_d  = ifc.req_ext ? '0 : idx_onehot(ifc.req_src);
          end
        end
      end
      DRIVE: begin
        state_d = LATCH;
        load_d  = idx_onehot(dst_q);
      end
      LATCH: begin
        // The destination register samples the bus on this same edge.
        state_d   = FIN;
        out_en_d  = '0;
        load_d    = '0;
        ext_drv_d = 1'b0;
        capture_d = bus;
        count_d   = sat_inc(count_q);
        done_d    = 1'b1;
      end
      FIN: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      ERR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        out_en_d    = '0;
        load_d      = '0;
        ext_drv_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      out_en_q    <= '0;
      load_q      <= '0;
      ext_drv_q   <= 1'b0;
      ext_word_q  <= '0;
      capture_q   <= '0;
      dst_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      out_en_q    <= out_en_d;
      load_q      <= load_d;
      ext_drv_q   <= ext_drv_d;
      ext_word_q  <= ext_word_d;
      capture_q   <= capture_d;
      dst_q       <= dst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  // Drive enable comes straight from a reset flop, so the bus floats as soon as reset asserts.
  assign bus = ext_drv_q ? ext_word_q : {data_size{1'bz}};

  assign ifc.req_ready   = req_ready_q;
  assign ifc.reg_out_en  = out_en_q;
  assign ifc.reg_load    = load_q;
  assign ifc.bus_capture = capture_q;
  assign ifc.done        = done_q;
  assign ifc.err         = err_q;
  assign ifc.xfer_count  = count_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with an eight-register bus model and a six-register reject-only instance.
module tb_bus_xfer_ctrl;

  localparam logic [31:0] PROBE = 32'h0F0F_0F0F;

  logic clk;
  logic reset;
  wire [31:0] bus8;
  wire [31:0] bus6;

  bus_xfer_ctrl_if #(.data_size(32), .NUM_REGS(8), .IDX_W(4)) ifc8 ();
  bus_xfer_ctrl_if #(.data_size(32), .NUM_REGS(6), .IDX_W(4)) ifc6 ();

  bus_xfer_ctrl #(.data_size(32), .NUM_REGS(8), .IDX_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc8.master),
    .bus   (bus8)
  );

  bus_xfer_ctrl #(.data_size(32), .NUM_REGS(6), .IDX_W(4)) dut6 (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc6.master),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register8 bank model sharing bus8
  logic [31:0] regs8 [0:7];
  logic        pre_en;
  logic [2:0]  pre_idx;
  logic [31:0] pre_val;
  logic        probe_en;
  logic [31:0] rd_val;
  logic        rd_en;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < 8; i++) if (ifc8.reg_out_en[i]) rd_val = regs8[i];
  end
  assign rd_en = |ifc8.reg_out_en;
  assign bus8  = probe_en ? PROBE : (rd_en ? rd_val : 32'hzzzz_zzzz);

  always @(posedge clk) begin
    if (pre_en) regs8[pre_idx] <= pre_val;
    for (int i = 0; i < 8; i++) if (ifc8.reg_load[i]) regs8[i] <= bus8;
  end

  typedef struct {
    int          dst;
    logic [31:0] val;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [0:7];
  logic [15:0] push_cnt;
  logic [31:0] last_cap;
  int          checks;
  int          errors;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] oh8(input int i);
    return 8'(1) << i;
  endfunction

  task automatic push_exp(input int dst, input logic [31:0] val);
    exp_t e;
    push_cnt++;
    e.dst = dst;
    e.val = val;
    e.cnt = push_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed done with no pending transfer, expected a queued entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_cap"}, ifc8.bus_capture, e.val);
      check({tag, "_reg"}, regs8[e.dst], e.val);
      check({tag, "_cnt"}, 32'(ifc8.xfer_count), 32'(e.cnt));
      model[e.dst] = e.val;
      last_cap     = e.val;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (ifc8.done !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_done"}, 32'(ifc8.done), 32'd1);
    check({tag, "_lat"}, n, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ifc8.req_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_rdy"}, 32'(ifc8.req_ready), 32'd1);
  endtask

  task automatic probe_bus(input string tag);
    probe_en = 1'b1;
    #1;
    check(tag, bus8, PROBE);
    probe_en = 1'b0;
    #1;
  endtask

  // Full legal transfer, entered with the controller in IDLE.
  task automatic xfer(input string tag, input int src, input int dst, input logic ext,
                      input logic [31:0] din);
    push_exp(dst, ext ? din : model[src]);
    ifc8.req_src   = 4'(src);
    ifc8.req_dst   = 4'(dst);
    ifc8.req_ext   = ext;
    ifc8.ext_din   = din;
    ifc8.req_valid = 1'b1;
    step();
    ifc8.req_valid = 1'b0;
    ifc8.ext_din   = 32'h0;
    check({tag, "_d_oe"}, 32'(ifc8.reg_out_en), ext ? 32'h0 : 32'(oh8(src)));
    check({tag, "_d_ld"}, 32'(ifc8.reg_load), 32'h0);
    if (ext) check({tag, "_d_bus"}, bus8, din);
    step();
    check({tag, "_l_oe"}, 32'(ifc8.reg_out_en), ext ? 32'h0 : 32'(oh8(src)));
    check({tag, "_l_ld"}, 32'(ifc8.reg_load), 32'(oh8(dst)));
    if (ext) check({tag, "_l_bus"}, bus8, din);
    step();
    wait_done(tag);
    pop_check(tag);
    check({tag, "_f_oe"}, 32'(ifc8.reg_out_en), 32'h0);
    probe_bus({tag, "_f_busz"});
    step();
    wait_ready(tag);
  endtask

  task automatic illegal8(input string tag, input int src, input int dst, input logic ext);
    ifc8.req_src   = 4'(src);
    ifc8.req_dst   = 4'(dst);
    ifc8.req_ext   = ext;
    ifc8.req_valid = 1'b1;
    step();
    ifc8.req_valid = 1'b0;
    check({tag, "_err"}, 32'(ifc8.err), 32'd1);
    check({tag, "_oe"}, 32'(ifc8.reg_out_en), 32'h0);
    check({tag, "_ld"}, 32'(ifc8.reg_load), 32'h0);
    check({tag, "_rdy0"}, 32'(ifc8.req_ready), 32'd0);
    step();
    check({tag, "_err0"}, 32'(ifc8.err), 32'd0);
    check({tag, "_done0"}, 32'(ifc8.done), 32'd0);
    check({tag, "_rdy1"}, 32'(ifc8.req_ready), 32'd1);
    check({tag, "_cnt"}, 32'(ifc8.xfer_count), 32'(push_cnt));
    check({tag, "_cap"}, ifc8.bus_capture, last_cap);
  endtask

  task automatic illegal6(input string tag, input int src, input int dst);
    ifc6.req_src   = 4'(src);
    ifc6.req_dst   = 4'(dst);
    ifc6.req_ext   = 1'b0;
    ifc6.req_valid = 1'b1;
    step();
    ifc6.req_valid = 1'b0;
    check({tag, "_err"}, 32'(ifc6.err), 32'd1);
    check({tag, "_oe"}, 32'(ifc6.reg_out_en), 32'h0);
    check({tag, "_ld"}, 32'(ifc6.reg_load), 32'h0);
    step();
    check({tag, "_err0"}, 32'(ifc6.err), 32'd0);
    check({tag, "_cnt"}, 32'(ifc6.xfer_count), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    push_cnt = '0;
    last_cap = '0;
    probe_en = 1'b0;
    pre_en   = 1'b0;
    pre_idx  = '0;
    pre_val  = '0;
    reset    = 1'b0;
    ifc8.req_valid = 1'b0; ifc8.req_src = '0; ifc8.req_dst = '0;
    ifc8.req_ext   = 1'b0; ifc8.ext_din = '0;
    ifc6.req_valid = 1'b0; ifc6.req_src = '0; ifc6.req_dst = '0;
    ifc6.req_ext   = 1'b0; ifc6.ext_din = '0;
    model[0] = 32'h0000_0000; model[1] = 32'h1111_1111;
    model[2] = 32'h1234_5678; model[3] = 32'h3333_3333;
    model[4] = 32'h4444_4444; model[5] = 32'h5555_5555;
    model[6] = 32'h6666_6666; model[7] = 32'h7777_7777;

    pre_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pre_idx = 3'(i);
      pre_val = model[i];
      step();
    end
    pre_en = 1'b0;

    // reset held with a request pending
    ifc8.req_src = 4'd2; ifc8.req_dst = 4'd5; ifc8.req_ext = 1'b0; ifc8.req_valid = 1'b1;
    step();
    step();
    check("rst_ready", 32'(ifc8.req_ready), 32'd1);
    check("rst_oe", 32'(ifc8.reg_out_en), 32'h0);
    check("rst_ld", 32'(ifc8.reg_load), 32'h0);
    check("rst_cnt", 32'(ifc8.xfer_count), 32'h0);
    check("rst_cap", ifc8.bus_capture, 32'h0);
    check("rst_done", 32'(ifc8.done), 32'h0);
    check("rst_err", 32'(ifc8.err), 32'h0);
    probe_bus("rst_busz");
    reset = 1'b1;

    xfer("r2r", 2, 5, 1'b0, 32'h0);
    xfer("ext0", 3, 0, 1'b1, 32'hDEAD_BEEF);
    xfer("ext_same", 3, 3, 1'b1, 32'hCAFE_0003);
    xfer("r7to6", 7, 6, 1'b0, 32'h0);

    illegal8("ill_same", 3, 3, 1'b0);
    illegal8("ill_src", 9, 2, 1'b0);
    illegal8("ill_dst", 0, 8, 1'b0);
    illegal8("ill_dstx", 0, 8, 1'b1);
    illegal6("n6_dst7", 0, 7);
    illegal6("n6_dst6", 1, 6);

    // back-to-back with req_valid held across both requests
    ifc8.req_src = 4'd5; ifc8.req_dst = 4'd1; ifc8.req_ext = 1'b0; ifc8.req_valid = 1'b1;
    push_exp(1, model[5]);
    step();
    check("b2b_oe1", 32'(ifc8.reg_out_en), 32'(oh8(5)));
    check("b2b_rdy_d", 32'(ifc8.req_ready), 32'd0);
    push_exp(6, model[3]);
    ifc8.req_src = 4'd3; ifc8.req_dst = 4'd6;
    step();
    check("b2b_rdy_l", 32'(ifc8.req_ready), 32'd0);
    step();
    check("b2b_rdy_f", 32'(ifc8.req_ready), 32'd0);
    check("b2b_done1", 32'(ifc8.done), 32'd1);
    pop_check("b2b1");
    step();
    check("b2b_rdy_i", 32'(ifc8.req_ready), 32'd1);
    check("b2b_oe_i", 32'(ifc8.reg_out_en), 32'h0);
    step();
    ifc8.req_valid = 1'b0;
    check("b2b_oe2", 32'(ifc8.reg_out_en), 32'(oh8(3)));
    step();
    check("b2b_ld2", 32'(ifc8.reg_load), 32'(oh8(6)));
    step();
    wait_done("b2b2");
    pop_check("b2b2");
    step();
    wait_ready("b2b_end");

    // reset asserted inside LATCH of an external transfer to reg4
    ifc8.req_src = 4'd0; ifc8.req_dst = 4'd4; ifc8.req_ext = 1'b1;
    ifc8.ext_din = 32'hCAFE_F00D; ifc8.req_valid = 1'b1;
    step();
    ifc8.req_valid = 1'b0;
    step();
    check("mid_ld", 32'(ifc8.reg_load), 32'(oh8(4)));
    check("mid_bus", bus8, 32'hCAFE_F00D);
    #2;
    reset = 1'b0;
    #1;
    check("mid_ld0", 32'(ifc8.reg_load), 32'h0);
    check("mid_oe0", 32'(ifc8.reg_out_en), 32'h0);
    check("mid_rdy", 32'(ifc8.req_ready), 32'd1);
    probe_bus("mid_busz");
    step();
    check("mid_done", 32'(ifc8.done), 32'd0);
    step();
    check("mid_reg4", regs8[4], model[4]);
    check("mid_cnt", 32'(ifc8.xfer_count), 32'h0);
    reset    = 1'b1;
    push_cnt = '0;
    last_cap = '0;

    xfer("post", 2, 4, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
